// File: rtl/mips_tb_harness_ctrl.sv
// ---------------------------------------------------------------------------
// mips_tb_harness_ctrl
//
// Purpose:
//   Self-checking test-harness controller that sits between a bench and a
//   mips_cpu_harvard instance. It holds a loadable instruction ROM that is
//   served at the reset vector and can optionally swap byte lanes. It also
//   sequences the CPU reset and clock enable. When the CPU halts it captures
//   register_v0, compares it with expected_v0, and reports pass, fail or
//   timeout.
//
// Optional feature (compile-time macro HARNESS_OOR_TRAP_EN):
//   When this macro is defined, any fetch during RUN from a non-zero address
//   that is out of range or misaligned ends the run. The run finishes with
//   fail=1, and the extra output oor_trap is raised.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   start          in   one-cycle pulse, begins or restarts a run
//   load_en        in   ROM write strobe (honoured only in IDLE/DONE)
//   load_addr      in   ROM word index
//   load_data      in   instruction word in logical (big-endian) order
//   expected_v0    in   expected final value of register_v0
//   instr_address  in   CPU fetch address
//   active         in   CPU active flag
//   register_v0    in   CPU $v0
//   instr_readdata out  fetched word presented to the CPU
//   cpu_reset      out  active-high reset to the CPU
//   clk_enable     out  CPU clock enable
//   result         out  captured register_v0
//   done           out  run finished
//   pass           out  run finished and result matched
//   fail           out  run finished with a mismatch, timeout or trap
//   timeout        out  run ended because the cycle budget ran out
//   cycle_count    out  number of RUN cycles elapsed (saturating)
//   oor_trap       out  (HARNESS_OOR_TRAP_EN only) bad fetch ended the run
// ---------------------------------------------------------------------------
module mips_tb_harness_ctrl #(
    parameter int          ROM_DEPTH    = 16,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          BYTE_SWAP    = 1,
    parameter int          RESET_CYCLES = 2,
    parameter int          MAX_CYCLES   = 1000,
    parameter int          CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         load_en,
    input  logic [$clog2(ROM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    input  logic [31:0]                  expected_v0,
    input  logic [31:0]                  instr_address,
    input  logic                         active,
    input  logic [31:0]                  register_v0,
    output logic [31:0]                  instr_readdata,
    output logic                         cpu_reset,
    output logic                         clk_enable,
    output logic [31:0]                  result,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycle_count
`ifdef HARNESS_OOR_TRAP_EN
    ,
    output logic                         oor_trap
`endif
);

    localparam int                AW        = $clog2(ROM_DEPTH);
    localparam logic [31:0]       ROM_BYTES = 32'(ROM_DEPTH * 4);
    localparam logic [AW:0]       DEPTH_EXT = (AW+1)'(ROM_DEPTH);
    localparam logic [CNT_W-1:0]  MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_SAT   = CNT_W'(MAX_CYCLES);
    localparam int                RC_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [RC_W-1:0] rst_cnt;

    logic [31:0] rom [ROM_DEPTH];
    logic [31:0] fetch_off;
    logic [AW-1:0] fetch_idx;
    logic [31:0] rom_word;
    logic        fetch_ok;
    logic        load_ok;

    logic enter_rst;
    logic halt_hit;
    logic timeout_hit;
`ifdef HARNESS_OOR_TRAP_EN
    logic trap_hit;
`endif

    // Fetch path. The offset is computed relative to the reset vector.
    // Addresses below the vector are rejected explicitly, so that the
    // modular subtraction cannot alias them back into the ROM window.
    always_comb begin
        fetch_off      = instr_address - RESET_VECTOR;
        fetch_ok       = (instr_address >= RESET_VECTOR) &&
                         (fetch_off[1:0] == 2'b00) &&
                         (fetch_off < ROM_BYTES);
        fetch_idx      = fetch_off[AW+1:2];
        rom_word       = rom[fetch_idx];
        instr_readdata = 32'h0;
        if (fetch_ok) begin
            if (BYTE_SWAP != 0) begin
                instr_readdata = {rom_word[7:0], rom_word[15:8],
                                  rom_word[23:16], rom_word[31:24]};
            end else begin
                instr_readdata = rom_word;
            end
        end
    end

    // ROM writes are only accepted while no run is in flight.
    // The ROM has no reset, so a rerun after a reset still sees the
    // program that was loaded before.
    assign load_ok = load_en && ((state == IDLE) || (state == DONE)) &&
                     ({1'b0, load_addr} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            rom[load_addr] <= load_data;
        end
    end

    // State register. Because cpu_reset and clk_enable are decoded from
    // the state, an asynchronous reset forces the CPU into reset at the
    // same instant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. A halt is checked first, so it takes
    // priority over an expiring cycle budget in the same cycle.
    always_comb begin
        next_state  = state;
        cpu_reset   = 1'b0;
        clk_enable  = 1'b0;
        done        = 1'b0;
        enter_rst   = 1'b0;
        halt_hit    = 1'b0;
        timeout_hit = 1'b0;
`ifdef HARNESS_OOR_TRAP_EN
        trap_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cpu_reset = 1'b1;
                if (start) begin
                    next_state = RST;
                    enter_rst  = 1'b1;
                end
            end
            RST: begin
                cpu_reset  = 1'b1;
                clk_enable = 1'b1;
                if (rst_cnt == RC_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                clk_enable = 1'b1;
                if (!active && (instr_address == 32'h0)) begin
                    halt_hit   = 1'b1;
                    next_state = CHECK;
                end
`ifdef HARNESS_OOR_TRAP_EN
                else if ((instr_address != 32'h0) && !fetch_ok) begin
                    trap_hit   = 1'b1;
                    next_state = DONE;
                end
`endif
                else if (cycle_count == MAX_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            CHECK: begin
                next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = RST;
                    enter_rst  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                cpu_reset  = 1'b1;
            end
        endcase
    end

    // Run bookkeeping. All status flags are cleared when a run is started,
    // and they are held through DONE until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result      <= 32'h0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            rst_cnt     <= '0;
`ifdef HARNESS_OOR_TRAP_EN
            oor_trap    <= 1'b0;
`endif
        end else if (enter_rst) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            rst_cnt     <= '0;
`ifdef HARNESS_OOR_TRAP_EN
            oor_trap    <= 1'b0;
`endif
        end else begin
            case (state)
                RST: begin
                    rst_cnt <= rst_cnt + 1'b1;
                end
                RUN: begin
                    if (cycle_count != MAX_SAT) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (timeout_hit) begin
                        timeout <= 1'b1;
                        fail    <= 1'b1;
                        result  <= register_v0;
                    end
`ifdef HARNESS_OOR_TRAP_EN
                    if (trap_hit) begin
                        oor_trap <= 1'b1;
                        fail     <= 1'b1;
                        result   <= register_v0;
                    end
`endif
                end
                CHECK: begin
                    result <= register_v0;
                    pass   <= (register_v0 == expected_v0);
                    fail   <= (register_v0 != expected_v0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_tb_harness_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_tb_harness_ctrl
//
// Purpose:
//   Bench for mips_tb_harness_ctrl. A small behavioural CPU stands in for
//   mips_cpu_harvard and executes addiu, jr $0, b and j from the fetched
//   words. Expected run outcomes and fetch words are queued when stimulus
//   is driven, and they are popped when the design answers. A second
//   instance built with BYTE_SWAP=0 covers the unswapped fetch path.
//   The oor_trap scenario is compiled only when HARNESS_OOR_TRAP_EN is
//   defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_tb_harness_ctrl;

    localparam logic [31:0] VEC   = 32'hBFC00000;
    localparam int          DEPTH = 16;
    localparam int          MAXC  = 50;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        start       = 1'b0;
    logic        load_en     = 1'b0;
    logic [3:0]  load_addr   = 4'd0;
    logic [31:0] load_data   = 32'h0;
    logic [31:0] expected_v0 = 32'h0;
    logic [31:0] instr_address;
    logic        active;
    logic [31:0] register_v0;

    logic [31:0] instr_readdata;
    logic        cpu_reset;
    logic        clk_enable;
    logic [31:0] result;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] cycle_count;

    logic [31:0] ns_instr_readdata;
    logic        ns_cpu_reset;
    logic        ns_clk_enable;
    logic [31:0] ns_result;
    logic        ns_done;
    logic        ns_pass;
    logic        ns_fail;
    logic        ns_timeout;
    logic [15:0] ns_cycle_count;
`ifdef HARNESS_OOR_TRAP_EN
    logic        oor_trap;
    logic        ns_oor_trap;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int run_cycles   = 0;

    logic [35:0] run_q[$];
    logic [63:0] fetch_q[$];

    always #5 clk = ~clk;

    mips_tb_harness_ctrl #(
        .ROM_DEPTH(DEPTH), .RESET_VECTOR(VEC), .BYTE_SWAP(1),
        .RESET_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .expected_v0(expected_v0),
        .instr_address(instr_address), .active(active), .register_v0(register_v0),
        .instr_readdata(instr_readdata), .cpu_reset(cpu_reset), .clk_enable(clk_enable),
        .result(result), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .cycle_count(cycle_count)
`ifdef HARNESS_OOR_TRAP_EN
        , .oor_trap(oor_trap)
`endif
    );

    mips_tb_harness_ctrl #(
        .ROM_DEPTH(DEPTH), .RESET_VECTOR(VEC), .BYTE_SWAP(0),
        .RESET_CYCLES(2), .MAX_CYCLES(MAXC), .CNT_W(16)
    ) dut_ns (
        .clk(clk), .reset(reset), .start(1'b0), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .expected_v0(expected_v0),
        .instr_address(instr_address), .active(active), .register_v0(register_v0),
        .instr_readdata(ns_instr_readdata), .cpu_reset(ns_cpu_reset),
        .clk_enable(ns_clk_enable), .result(ns_result), .done(ns_done),
        .pass(ns_pass), .fail(ns_fail), .timeout(ns_timeout),
        .cycle_count(ns_cycle_count)
`ifdef HARNESS_OOR_TRAP_EN
        , .oor_trap(ns_oor_trap)
`endif
    );

    // Behavioural CPU. It models a delay slot through pc/npc. Fetched words
    // arrive byte-swapped, so they are swapped back before decode. "b" is
    // treated as relative to its own address, which makes 0x10000000 a
    // self-loop. Fetching from address 0 makes the CPU inactive.
    logic [31:0] pc    = VEC;
    logic [31:0] npc   = VEC + 32'd4;
    logic [31:0] v0    = 32'h0;
    logic        act   = 1'b1;
    logic        force_en   = 1'b0;
    logic [31:0] force_addr = 32'h0;
    logic [31:0] cpu_word;

    assign instr_address = force_en ? force_addr : pc;
    assign active        = act;
    assign register_v0   = v0;
    assign cpu_word      = {instr_readdata[7:0], instr_readdata[15:8],
                            instr_readdata[23:16], instr_readdata[31:24]};

    always @(posedge clk) begin
        if (cpu_reset) begin
            pc  <= VEC;
            npc <= VEC + 32'd4;
            v0  <= 32'h0;
            act <= 1'b1;
        end else if (clk_enable && act) begin
            if (pc == 32'h0) begin
                act <= 1'b0;
            end else begin
                pc <= npc;
                case (cpu_word[31:26])
                    6'h02:   npc <= {npc[31:28], cpu_word[25:0], 2'b00};
                    6'h04:   npc <= pc + {{14{cpu_word[15]}}, cpu_word[15:0], 2'b00};
                    6'h09: begin
                        if (cpu_word[20:16] == 5'd2) v0 <= {{16{cpu_word[15]}}, cpu_word[15:0]};
                        npc <= npc + 32'd4;
                    end
                    6'h00: begin
                        if (cpu_word[5:0] == 6'h08) npc <= 32'h0;
                        else npc <= npc + 32'd4;
                    end
                    default: npc <= npc + 32'd4;
                endcase
            end
        end
    end

    // Counts cycles in which the CPU is running, for the timeout check.
    always @(negedge clk) begin
        if (!cpu_reset && clk_enable) run_cycles <= run_cycles + 1;
    end

    task automatic load_word(input int idx, input logic [31:0] w);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = idx[3:0];
        load_data = w;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({cpu_reset, clk_enable, done, pass, fail, timeout} !== 6'b100000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b required 100000",
                     {cpu_reset, clk_enable, done, pass, fail, timeout});
        end
        tests_run++;
        if (result !== 32'h0 || cycle_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got result=%h count=%0d required 0/0", result, cycle_count);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cpu_reset, clk_enable, done} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL idle_hold: got %b required 100", {cpu_reset, clk_enable, done});
        end
    endtask

    task automatic test_fetch();
        logic [31:0] addr_tab [6];
        logic [63:0] exp_tab  [6];
        logic [63:0] exp;
        addr_tab = '{32'hBFC00000, 32'hBFC00002, 32'hBFC00040,
                     32'hBFC0003C, 32'hBFBFFFFC, 32'h00000000};
        exp_tab  = '{{32'h05000224, 32'h24020005}, 64'h0, 64'h0,
                     {32'h21000000, 32'h00000021}, 64'h0, 64'h0};
        load_word(0, 32'h24020005);
        load_word(15, 32'h00000021);
        force_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_q.push_back(exp_tab[i]);
            force_addr = addr_tab[i];
            #1;
            exp = fetch_q.pop_front();
            tests_run++;
            if ({instr_readdata, ns_instr_readdata} !== exp) begin
                tests_failed++;
                $display("[TB] FAIL fetch@%h: got swap=%h noswap=%h required %h/%h",
                         addr_tab[i], instr_readdata, ns_instr_readdata, exp[63:32], exp[31:0]);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_pass();
        logic [35:0] exp;
        logic [35:0] obs;
        bit got;
        load_word(0, 32'h24020005);
        load_word(1, 32'h00000008);
        load_word(2, 32'h00000000);
        expected_v0 = 32'd5;
        run_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 32'd5});
        pulse_start();
        wait_done(200, got);
        exp = run_q.pop_front();
        obs = {done, pass, fail, timeout, result};
        tests_run++;
        if (!got || obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL pass_run: got dpft=%b result=%h required dpft=%b result=%h",
                     obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic test_mismatch();
        logic [35:0] exp;
        logic [35:0] obs;
        bit got;
        expected_v0 = 32'd6;
        run_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'd5});
        pulse_start();
        wait_done(200, got);
        exp = run_q.pop_front();
        obs = {done, pass, fail, timeout, result};
        tests_run++;
        if (!got || obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_run: got dpft=%b result=%h required dpft=%b result=%h",
                     obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic test_timeout();
        logic [35:0] exp;
        logic [35:0] obs;
        bit got;
        int base;
        load_word(0, 32'h10000000);
        load_word(1, 32'h00000000);
        expected_v0 = 32'd5;
        base = run_cycles;
        run_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 32'd0});
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(200, got);
        exp = run_q.pop_front();
        obs = {done, pass, fail, timeout, result};
        tests_run++;
        if (!got || obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL timeout_run: got dpft=%b result=%h required dpft=%b result=%h",
                     obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
        end
        tests_run++;
        if (cycle_count !== 16'(MAXC)) begin
            tests_failed++;
            $display("[TB] FAIL timeout_count: got %0d required %0d", cycle_count, MAXC);
        end
        tests_run++;
        if (run_cycles - base !== MAXC) begin
            tests_failed++;
            $display("[TB] FAIL timeout_run_cycles: got %0d required %0d", run_cycles - base, MAXC);
        end
    endtask

    task automatic test_load_during_run();
        logic [35:0] exp;
        logic [35:0] obs;
        bit got;
        bit in_run;
        load_word(0, 32'h24020005);
        load_word(1, 32'h00000008);
        load_word(2, 32'h00000000);
        expected_v0 = 32'd5;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            run_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 32'd5});
            pulse_start();
            if (pass_no == 0) begin
                in_run = 1'b0;
                for (int i = 0; i < 20 && !in_run; i++) begin
                    @(negedge clk);
                    if (cpu_reset === 1'b0) in_run = 1'b1;
                end
                load_en   = 1'b1;
                load_addr = 4'd0;
                load_data = 32'h24020007;
                @(negedge clk);
                load_en   = 1'b0;
            end
            wait_done(200, got);
            exp = run_q.pop_front();
            obs = {done, pass, fail, timeout, result};
            tests_run++;
            if (!got || obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL load_in_run_%0d: got dpft=%b result=%h required dpft=%b result=%h",
                         pass_no, obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        load_word(0, 32'h10000000);
        load_word(1, 32'h00000000);
        pulse_start();
        repeat (6) @(negedge clk);
        tests_run++;
        if ({cpu_reset, clk_enable} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL midrun_pre: got %b required 01", {cpu_reset, clk_enable});
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({cpu_reset, clk_enable, done, fail, timeout} !== 5'b10000 || cycle_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got ctrl=%b count=%0d required 10000/0",
                     {cpu_reset, clk_enable, done, fail, timeout}, cycle_count);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cpu_reset, clk_enable, done} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL midrun_idle: got %b required 100", {cpu_reset, clk_enable, done});
        end
    endtask

`ifdef HARNESS_OOR_TRAP_EN
    task automatic test_oor_trap();
        logic [35:0] exp;
        logic [35:0] obs;
        bit seen;
        load_word(0, 32'h0BF00400);
        load_word(1, 32'h00000000);
        expected_v0 = 32'd0;
        run_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'd0});
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (instr_address === 32'hBFC01000 && cpu_reset === 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (!seen || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL trap_fetch: got seen=%0d done=%b required 1/0", seen, done);
        end
        @(negedge clk);
        exp = run_q.pop_front();
        obs = {done, pass, fail, timeout, result};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL trap_run: got dpft=%b result=%h required dpft=%b result=%h",
                     obs[35:32], obs[31:0], exp[35:32], exp[31:0]);
        end
        tests_run++;
        if (oor_trap !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL trap_flag: got %b required 1", oor_trap);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_pass();
        test_mismatch();
        test_timeout();
        test_load_during_run();
        test_reset_midrun();
`ifdef HARNESS_OOR_TRAP_EN
        test_oor_trap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
